// File: rtl/mux_16b_2to1.sv
// 16-bit two-input word multiplexer built from sixteen identical 1-bit gate cells.
// A registered copy of the selected word is provided for pipeline-boundary use.

module mux_2to1_cell (
  input  logic in1,
  input  logic in2,
  input  logic sel,
  output logic out
);

  assign out = (~sel & in1) | (sel & in2);

endmodule

module mux_16b_2to1 (
  output logic [15:0] out,
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic        sel,
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] out_q
);

  // Combinational datapath: one gate cell per bit, sel fanned out to every cell,
  // so out stays correct even when clk/rst are left unconnected.
  for (genvar i = 0; i < 16; i++) begin : g_bit
    mux_2to1_cell u_cell (
      .in1 (in1[i]),
      .in2 (in2[i]),
      .sel (sel),
      .out (out[i])
    );
  end

  // Pipeline-boundary copy of the selected word; cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= 16'h0000;
    end else begin
      out_q <= out;
    end
  end

endmodule

// File: tb/tb_mux_16b_2to1.sv
// Directed and random checks of mux_16b_2to1: combinational select, bit independence,
// walking-one, register/reset behaviour and registered-copy latency.

module tb_mux_16b_2to1;

  logic [15:0] out;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        sel;
  logic        clk;
  logic        rst;
  logic [15:0] out_q;

  int checks   = 0;
  int failures = 0;

  mux_16b_2to1 dut (
    .out   (out),
    .in1   (in1),
    .in2   (in2),
    .sel   (sel),
    .clk   (clk),
    .rst   (rst),
    .out_q (out_q)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Inputs change just after the rising edge, outputs are sampled on the falling edge.
  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic s, input logic r);
    @(posedge clk);
    #1;
    in1 = a;
    in2 = b;
    sel = s;
    rst = r;
  endtask

  task automatic test_reset();
    drive(16'h0000, 16'h0000, 1'b0, 1'b1);
    drive(16'h0000, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (out_q !== 16'h0000) begin
      failures++;
      $display("FAIL reset_out_q: got %h expected %h", out_q, 16'h0000);
    end
    checks++;
    if (out !== 16'h0000) begin
      failures++;
      $display("FAIL reset_out: got %h expected %h", out, 16'h0000);
    end
  endtask

  task automatic test_basic();
    drive(16'h1234, 16'hABCD, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (out !== 16'h1234) begin
      failures++;
      $display("FAIL basic_sel0: got %h expected %h", out, 16'h1234);
    end
    drive(16'h1234, 16'hABCD, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (out !== 16'hABCD) begin
      failures++;
      $display("FAIL basic_sel1: got %h expected %h", out, 16'hABCD);
    end
    checks++;
    if (out_q !== 16'h1234) begin
      failures++;
      $display("FAIL basic_out_q: got %h expected %h", out_q, 16'h1234);
    end
  endtask

  task automatic test_bit_independence();
    logic [15:0] a_tab [4] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
    logic [15:0] b_tab [4] = '{16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
    logic        s_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] e_tab [4] = '{16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF};
    for (int i = 0; i < 4; i++) begin
      drive(a_tab[i], b_tab[i], s_tab[i], 1'b0);
      @(negedge clk);
      checks++;
      if (out !== e_tab[i]) begin
        failures++;
        $display("FAIL bit_indep[%0d]: got %h expected %h", i, out, e_tab[i]);
      end
    end
  endtask

  task automatic test_walking_one();
    logic [15:0] a;
    logic [15:0] e;
    logic [15:0] one;
    one = 16'h0001;
    for (int k = 0; k < 16; k++) begin
      a = one << k;
      e = (k % 2 == 1) ? ~a : a;
      drive(a, ~a, k[0], 1'b0);
      @(negedge clk);
      checks++;
      if (out !== e) begin
        failures++;
        $display("FAIL walk_one[k=%0d sel=%0b]: got %h expected %h", k, k[0], out, e);
      end
    end
  endtask

  task automatic test_reg_reset();
    drive(16'h5A5A, 16'h0000, 1'b0, 1'b1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (out !== 16'h5A5A) begin
        failures++;
        $display("FAIL rst_out[%0d]: got %h expected %h", c, out, 16'h5A5A);
      end
      if (c == 1) begin
        checks++;
        if (out_q !== 16'h0000) begin
          failures++;
          $display("FAIL rst_out_q: got %h expected %h", out_q, 16'h0000);
        end
      end
      if (c == 0) drive(16'h5A5A, 16'h0000, 1'b0, 1'b1);
    end
    drive(16'h5A5A, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (out_q !== 16'h0000) begin
      failures++;
      $display("FAIL rst_held_out_q: got %h expected %h", out_q, 16'h0000);
    end
    drive(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (out_q !== 16'h5A5A) begin
      failures++;
      $display("FAIL post_rst_load: got %h expected %h", out_q, 16'h5A5A);
    end
    drive(16'h1111, 16'h2222, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (out_q !== 16'h1111) begin
      failures++;
      $display("FAIL pre_rst_load: got %h expected %h", out_q, 16'h1111);
    end
    drive(16'h1111, 16'h2222, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (out_q !== 16'h0000) begin
      failures++;
      $display("FAIL mid_rst_clear: got %h expected %h", out_q, 16'h0000);
    end
    checks++;
    if (out !== 16'h2222) begin
      failures++;
      $display("FAIL mid_rst_out: got %h expected %h", out, 16'h2222);
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] e;
    logic [15:0] prev_e;
    drive(16'hC3C3, 16'h3C3C, 1'b1, 1'b0);
    prev_e = 16'h3C3C;
    for (int i = 0; i < 32; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      s = 1'($urandom_range(0, 1));
      e = s ? b : a;
      drive(a, b, s, 1'b0);
      @(negedge clk);
      checks++;
      if (out !== e) begin
        failures++;
        $display("FAILED rand_out[%0d]: in1=%h in2=%h sel=%0b out=%h expected %h", i, a, b, s, out, e);
      end else begin
        $display("PASSED rand_out[%0d]: in1=%h in2=%h sel=%0b out=%h", i, a, b, s, out);
      end
      checks++;
      if (out_q !== prev_e) begin
        failures++;
        $display("FAIL rand_out_q[%0d]: got %h expected %h", i, out_q, prev_e);
      end
      prev_e = e;
    end
  endtask

  initial begin
    in1 = 16'h0000;
    in2 = 16'h0000;
    sel = 1'b0;
    rst = 1'b1;
    test_reset();
    test_basic();
    test_bit_independence();
    test_walking_one();
    test_reg_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
